// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator: scans DIGIT bits per clock and
// stops at the first differing digit. Signed compares use an offset-binary remap.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             agreater,
    output logic             bgreater
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NDIG - 1);
    localparam logic [IDXW-1:0]  IDX_ONE  = IDXW'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             done_reg;
    logic             equal_reg;
    logic             agreater_reg;
    logic             bgreater_reg;

    logic [NDIG-1:0]  dig_gt;
    logic [NDIG-1:0]  dig_lt;
    logic             cur_gt;
    logic             cur_lt;
    logic [WIDTH-1:0] offset_mask;

    // Per-digit unsigned order of the latched copies; the scan just selects one.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign dig_gt[gi] = a_reg[gi*DIGIT +: DIGIT] > b_reg[gi*DIGIT +: DIGIT];
            assign dig_lt[gi] = a_reg[gi*DIGIT +: DIGIT] < b_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    assign cur_gt = dig_gt[idx_reg];
    assign cur_lt = dig_lt[idx_reg];

    // Flipping both sign bits turns two's-complement order into unsigned order.
    assign offset_mask = signed_mode ? MSB_MASK : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            idx_reg      <= '0;
            done_reg     <= 1'b0;
            equal_reg    <= 1'b0;
            agreater_reg <= 1'b0;
            bgreater_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a ^ offset_mask;
                        b_reg     <= b ^ offset_mask;
                        idx_reg   <= IDX_TOP;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_gt || cur_lt) begin
                        agreater_reg <= cur_gt;
                        bgreater_reg <= cur_lt;
                        equal_reg    <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= IDLE;
                    end else if (idx_reg == '0) begin
                        agreater_reg <= 1'b0;
                        bgreater_reg <= 1'b0;
                        equal_reg    <= 1'b1;
                        done_reg     <= 1'b1;
                        state_reg    <= IDLE;
                    end else begin
                        idx_reg <= idx_reg - IDX_ONE;
                    end
                end
            endcase
        end
    end

    assign busy     = (state_reg == SCAN);
    assign done     = done_reg;
    assign equal    = equal_reg;
    assign agreater = agreater_reg;
    assign bgreater = bgreater_reg;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4):
// vector table plus handshake, hold and mid-scan reset sequences.
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        equal;
    logic        agreater;
    logic        bgreater;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic        eq;
        logic        agt;
        logic        bgt;
        int          lat;
    } vec_t;

    typedef struct {
        logic eq;
        logic agt;
        logic bgt;
        int   lat;
        int   launch_cyc;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[13];

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_mode(signed_mode),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .equal      (equal),
        .agreater   (agreater),
        .bgreater   (bgreater)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge with start dropped.
    task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vsm,
                          input logic eq, input logic agt, input logic bgt, input int lat);
        exp_t e;
        a = va;
        b = vb;
        signed_mode = vsm;
        start = 1'b1;
        e.eq = eq;
        e.agt = agt;
        e.bgt = bgt;
        e.lat = lat;
        e.launch_cyc = cyc;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done(input string name);
        int   guard;
        int   lat;
        exp_t e;
        guard = 0;
        while (!done && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: done not seen, expected within 64 cycles", name);
        end
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_scoreboard: queue empty, expected an entry", name);
        end else begin
            e = sbq.pop_front();
            lat = cyc - e.launch_cyc - 1;
            check({name, "_result"}, 32'({equal, agreater, bgreater}), 32'({e.eq, e.agt, e.bgt}));
            check({name, "_latency"}, 32'(lat), 32'(e.lat));
            check({name, "_busy_low_at_done"}, 32'(busy), 32'd0);
            $display("[TB] %s a=%h b=%h sm=%0d -> eq=%0d agt=%0d bgt=%0d lat=%0d (exp %0d%0d%0d lat %0d)",
                     name, a, b, signed_mode, equal, agreater, bgreater, lat,
                     e.eq, e.agt, e.bgt, e.lat);
        end
    endtask

    initial begin
        logic saw_done;
        // {a, b, signed_mode, equal, agreater, bgreater, latency}
        vecs[0]  = '{16'h9000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        vecs[2]  = '{16'h1235, 16'h1236, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        vecs[3]  = '{16'hABCD, 16'hAB0D, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[4]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4};
        vecs[8]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[9]  = '{16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        vecs[10] = '{16'h00F0, 16'h00E0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[11] = '{16'h0010, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[12] = '{16'h8001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 4};

        rst_n = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy, done, equal, agreater, bgreater}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs_before_first_op", 32'({busy, done, equal, agreater, bgreater}), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].eq, vecs[i].agt, vecs[i].bgt, vecs[i].lat);
            wait_done($sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Results hold between operations
        launch(16'h0F00, 16'h0E00, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        wait_done("hold_op");
        repeat (4) @(negedge clk);
        check("hold_results", 32'({equal, agreater, bgreater}), 32'b010);
        check("hold_done_low", 32'(done), 32'd0);

        // Start while busy is ignored
        launch(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        a = 16'h0000;
        b = 16'hFFFF;
        signed_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_busy_start");
        @(negedge clk);
        check("ignored_start_not_queued", 32'({busy, done}), 32'd0);

        // Back-to-back: start during the done cycle
        launch(16'h5555, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        wait_done("b2b_first");
        launch(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        wait_done("b2b_second");
        @(negedge clk);

        // Reset mid-scan aborts without a done
        launch(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midscan_reset_outputs", 32'({busy, done, equal, agreater, bgreater}), 32'd0);
        void'(sbq.pop_back());
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("aborted_op_no_done", 32'(saw_done), 32'd0);
        rst_n = 1'b1;
        launch(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        wait_done("after_reset");
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
